// File: rtl/register_writeback_arbiter.sv
// Round-robin owner of the integer register file write port, with a per-register
// pending-write scoreboard that decode uses to detect read-after-write hazards.
module register_writeback_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 5,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DEPTH-1:0]   req_index,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       reserve_valid,
    input  logic [DEPTH-1:0]           reserve_index,
    input  logic [DEPTH-1:0]           check_index_1,
    input  logic [DEPTH-1:0]           check_index_2,
    output logic                       hazard_1,
    output logic                       hazard_2,
    output logic [(2**DEPTH)-1:0]      busy_vector,
    output logic                       rf_write_enable,
    output logic [DEPTH-1:0]           rf_write_index,
    output logic [WIDTH-1:0]           rf_write_data
);

    localparam int unsigned NUM_REGS = 2 ** DEPTH;
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_idx;
    logic                transfer;
    logic [NUM_REQ-1:0]  grant;
    logic [DEPTH-1:0]    sel_index;
    logic [WIDTH-1:0]    sel_data;
    logic [NUM_REGS-1:0] busy_next;

    // Round-robin search starting at the pointer; nothing is granted while in reset.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        transfer  = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!transfer && !reset && req_valid[PTR_W'(cand)]) begin
                transfer  = 1'b1;
                grant_idx = PTR_W'(cand);
            end
        end
        grant = transfer ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    assign req_ready = grant;

    // Mux the granted requester's index and data.
    always_comb begin
        sel_index = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_index = req_index[i*DEPTH +: DEPTH];
                sel_data  = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves just past the last granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Registered write port; index 0 writes are accepted but never reach the file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_index  <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= transfer && (sel_index != '0);
            if (transfer && (sel_index != '0)) begin
                rf_write_index <= sel_index;
                rf_write_data  <= sel_data;
            end
        end
    end

    // Scoreboard update: commit clears, reservation sets and wins on a collision.
    always_comb begin
        busy_next = busy_vector;
        if (rf_write_enable) begin
            busy_next[rf_write_index] = 1'b0;
        end
        if (reserve_valid && (reserve_index != '0)) begin
            busy_next[reserve_index] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vector <= '0;
        end else begin
            busy_vector <= busy_next;
        end
    end

    // Hazard lookups for the two decoded sources; register 0 never stalls.
    always_comb begin
        hazard_1 = busy_vector[check_index_1] && (check_index_1 != '0);
        hazard_2 = busy_vector[check_index_2] && (check_index_2 != '0);
    end

endmodule

// File: tb/tb_register_writeback_arbiter.sv
// Directed bench for register_writeback_arbiter; expected register-file writes are
// queued by the stimulus and matched by an independent write-port monitor.
module tb_register_writeback_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 5;
    localparam int unsigned NUM_REQ = 2;

    typedef struct {
        logic [DEPTH-1:0] idx;
        logic [WIDTH-1:0] data;
    } wr_t;

    logic                     clk;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*DEPTH-1:0] req_index;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     reserve_valid;
    logic [DEPTH-1:0]         reserve_index;
    logic [DEPTH-1:0]         check_index_1;
    logic [DEPTH-1:0]         check_index_2;
    logic                     hazard_1;
    logic                     hazard_2;
    logic [(2**DEPTH)-1:0]    busy_vector;
    logic                     rf_write_enable;
    logic [DEPTH-1:0]         rf_write_index;
    logic [WIDTH-1:0]         rf_write_data;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    register_writeback_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_REQ(NUM_REQ)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .reserve_valid   (reserve_valid),
        .reserve_index   (reserve_index),
        .check_index_1   (check_index_1),
        .check_index_2   (check_index_2),
        .hazard_1        (hazard_1),
        .hazard_2        (hazard_2),
        .busy_vector     (busy_vector),
        .rf_write_enable (rf_write_enable),
        .rf_write_index  (rf_write_index),
        .rf_write_data   (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DEPTH-1:0] idx, input logic [WIDTH-1:0] data);
        wr_t w;
        w.idx  = idx;
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Write-port monitor: every committed write must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && rf_write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got idx %0d data %0h expected no write at %0t",
                         rf_write_index, rf_write_data, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("mon_index", 64'(rf_write_index), 64'(w.idx));
                check("mon_data",  64'(rf_write_data),  64'(w.data));
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        reset         = 1'b1;
        req_valid     = '0;
        req_index     = '0;
        req_data      = '0;
        reserve_valid = 1'b0;
        reserve_index = '0;
        check_index_1 = '0;
        check_index_2 = '0;
        tick();
        tick();
        check("reset_en",    64'(rf_write_enable), 64'(0));
        check("reset_busy",  64'(busy_vector),     64'(0));
        check("reset_ready", 64'(req_ready),       64'(0));
        reset = 1'b0;

        // Async reset drops an in-flight write and a reservation.
        req_valid      = 2'b01;
        req_index[4:0] = 5'd6;
        req_data[31:0] = 32'h1111_0006;
        reserve_valid  = 1'b1;
        reserve_index  = 5'd6;
        check_index_1  = 5'd6;
        #1;
        check("t1_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid     = '0;
        reserve_valid = 1'b0;
        check("t1_inflight_en", 64'(rf_write_enable), 64'(1));
        check("t1_busy_set",    64'(busy_vector),     64'(32'h0000_0040));
        #1 reset = 1'b1;
        #1;
        check("t1_rst_en",     64'(rf_write_enable), 64'(0));
        check("t1_rst_index",  64'(rf_write_index),  64'(0));
        check("t1_rst_data",   64'(rf_write_data),   64'(0));
        check("t1_rst_busy",   64'(busy_vector),     64'(0));
        check("t1_rst_hazard", 64'(hazard_1),        64'(0));
        tick();
        reset = 1'b0;

        // Both requesters valid: grants alternate 0,1,0,1.
        d0 = 32'hA000_0000;
        d1 = 32'hB000_0000;
        req_valid       = 2'b11;
        req_index[4:0]  = 5'd3;
        req_index[9:5]  = 5'd4;
        for (int k = 0; k < 4; k++) begin
            req_data[31:0]  = d0;
            req_data[63:32] = d1;
            #1;
            if (k % 2 == 0) begin
                check("t2_ready", 64'(req_ready), 64'(2'b01));
                push(5'd3, d0);
            end else begin
                check("t2_ready", 64'(req_ready), 64'(2'b10));
                push(5'd4, d1);
            end
            tick();
            if (k % 2 == 0) d0 = d0 + 32'd1;
            else            d1 = d1 + 32'd1;
        end
        req_valid = '0;

        // Single requester 1 to index 7.
        req_valid       = 2'b10;
        req_index[9:5]  = 5'd7;
        req_data[63:32] = 32'hDEAD_BEEF;
        #1;
        check("t3_ready", 64'(req_ready), 64'(2'b10));
        push(5'd7, 32'hDEAD_BEEF);
        tick();
        req_valid = '0;
        check("t3_en",    64'(rf_write_enable), 64'(1));
        check("t3_index", 64'(rf_write_index),  64'(7));
        check("t3_data",  64'(rf_write_data),   64'(32'hDEAD_BEEF));
        req_valid = 2'b11;
        #1;
        check("t3_ptr_zero", 64'(req_ready), 64'(2'b01));
        req_valid = '0;
        tick();

        // Reserve 5: hazard until the commit edge of the write to 5.
        reserve_valid = 1'b1;
        reserve_index = 5'd5;
        check_index_1 = 5'd5;
        check_index_2 = 5'd0;
        tick();
        reserve_valid = 1'b0;
        #1;
        check("t4_hz1_set",  64'(hazard_1),    64'(1));
        check("t4_hz2",      64'(hazard_2),    64'(0));
        check("t4_busy",     64'(busy_vector), 64'(32'h0000_0020));
        tick();
        check("t4_hz1_hold", 64'(hazard_1),    64'(1));
        req_valid       = 2'b01;
        req_index[4:0]  = 5'd5;
        req_data[31:0]  = 32'h5555_5555;
        #1;
        check("t4_ready", 64'(req_ready), 64'(2'b01));
        push(5'd5, 32'h5555_5555);
        tick();
        req_valid = '0;
        check("t4_hz1_wr_cycle", 64'(hazard_1), 64'(1));
        tick();
        check("t4_hz1_clear", 64'(hazard_1),    64'(0));
        check("t4_busy_clr",  64'(busy_vector), 64'(0));
        check("t4_hz2_end",   64'(hazard_2),    64'(0));

        // Reserve and commit of index 9 on the same edge: reservation wins.
        reserve_valid = 1'b1;
        reserve_index = 5'd9;
        check_index_1 = 5'd9;
        tick();
        reserve_valid   = 1'b0;
        req_valid       = 2'b10;
        req_index[9:5]  = 5'd9;
        req_data[63:32] = 32'h9999_9999;
        #1;
        check("t5_ready", 64'(req_ready), 64'(2'b10));
        push(5'd9, 32'h9999_9999);
        tick();
        req_valid     = '0;
        reserve_valid = 1'b1;
        reserve_index = 5'd9;
        tick();
        reserve_valid = 1'b0;
        check("t5_busy9", 64'(busy_vector), 64'(32'h0000_0200));
        check("t5_hz1",   64'(hazard_1),    64'(1));

        // Write and reservation to index 0: accepted, never committed, busy unchanged.
        req_valid      = 2'b01;
        req_index[4:0] = 5'd0;
        req_data[31:0] = 32'h0BAD_0BAD;
        reserve_valid  = 1'b1;
        reserve_index  = 5'd0;
        #1;
        check("t6_ready", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid     = '0;
        reserve_valid = 1'b0;
        check("t6_en",    64'(rf_write_enable), 64'(0));
        check("t6_busy",  64'(busy_vector),     64'(32'h0000_0200));
        check("t6_index", 64'(rf_write_index),  64'(9));
        check("t6_data",  64'(rf_write_data),   64'(32'h9999_9999));
        tick();
        check("t6_en_after", 64'(rf_write_enable), 64'(0));

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
